// File: rtl/serial_tcmp_pkg.sv
// Shared constants for the bit-serial two's-complement array.
//   TCMP_DEF_CH : default number of serial lanes
//   TCMP_DEF_W  : default word length in bits
//   tcmp_clog2  : constant ceil(log2) for parameter derivation
package serial_tcmp_pkg;

    localparam int TCMP_DEF_CH = 4;
    localparam int TCMP_DEF_W  = 8;

    function automatic int tcmp_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_tcmp_array_lane.sv
// One lane of the serial two's-complement unit.
// Ports:
//   clk, rst     : clock, async active-low reset
//   accept       : the current input slice is taken into the word
//   sof          : current slice is bit 0 of a new word
//   last         : current slice is bit W-1 of the word
//   bit_in       : this lane's serial input bit
//   neg_en       : negate enable, only looked at on sof
//   out_bit, ovf : registered result bit and overflow flag
module tcmp_lane (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic sof,
    input  logic last,
    input  logic bit_in,
    input  logic neg_en,
    output logic out_bit,
    output logic ovf
);

    logic seen_one;
    logic neg_q;
    logic seen;
    logic neg;

    // On a sof slice the word restarts, so history and mode come from this
    // cycle rather than from the registers.
    always_comb begin
        seen = sof ? 1'b0 : seen_one;
        neg  = sof ? neg_en : neg_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_one <= 1'b0;
            neg_q    <= 1'b0;
            out_bit  <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            seen_one <= seen | bit_in;
            neg_q    <= neg;
            // Serial negate: copy bits up to and including the first 1,
            // invert everything after it.
            out_bit  <= neg ? (bit_in ^ seen) : bit_in;
            // Only 100...0 reaches the MSB as a 1 with no earlier 1.
            ovf      <= last & neg & bit_in & ~seen;
        end else begin
            out_bit  <= 1'b0;
            ovf      <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_tcmp_array.sv
// Multi-lane, word-framed, bit-serial two's-complement unit.
// Ports:
//   clk, rst        : clock, async active-low reset
//   in_valid        : in_bits carries a slice this cycle
//   in_sof          : slice is bit 0 of a new word
//   in_bits[CH]     : one serial bit per lane, LSB first
//   neg_en[CH]      : per-lane negate enable, sampled on sof
//   out_valid       : out_bits valid (1-cycle latency)
//   out_bits[CH]    : per-lane result bit
//   out_sof/out_eof : result bit is bit 0 / bit W-1 of the word
//   ovf[CH]         : most-negative value was negated, with out_eof
//   frame_err       : sof arrived while a word was in progress
//   busy            : a word is in progress
module serial_tcmp_array
    import serial_tcmp_pkg::*;
#(
    parameter int CH    = TCMP_DEF_CH,
    parameter int W     = TCMP_DEF_W,
    parameter int CNT_W = tcmp_clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [CH-1:0] in_bits,
    input  logic [CH-1:0] neg_en,
    output logic          out_valid,
    output logic [CH-1:0] out_bits,
    output logic          out_sof,
    output logic          out_eof,
    output logic [CH-1:0] ovf,
    output logic          frame_err,
    output logic          busy
);

    logic [CNT_W-1:0] cnt;
    logic             frame_active;
    logic             accept;
    logic             last;
    logic             mid_sof;

    // A bit without sof while idle is not part of any word and is dropped.
    assign accept  = in_valid & (in_sof | frame_active);
    // sof always restarts at count 0, so a sof slice is never the last bit.
    assign last    = accept & ~in_sof & (cnt == CNT_W'(W - 1));
    assign mid_sof = accept & in_sof & frame_active;
    assign busy    = frame_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            frame_active <= 1'b0;
            out_valid    <= 1'b0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            out_valid <= accept;
            out_sof   <= accept & in_sof;
            out_eof   <= last;
            frame_err <= mid_sof;
            if (accept) begin
                if (in_sof) begin
                    cnt          <= CNT_W'(1);
                    frame_active <= 1'b1;
                end else if (last) begin
                    cnt          <= '0;
                    frame_active <= 1'b0;
                end else begin
                    cnt          <= cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        tcmp_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .accept  (accept),
            .sof     (in_sof),
            .last    (last),
            .bit_in  (in_bits[i]),
            .neg_en  (neg_en[i]),
            .out_bit (out_bits[i]),
            .ovf     (ovf[i])
        );
    end

endmodule
